mem_load_stage: RTL and testbench

- Parametrised memory-access pipeline stage between EX and WB; successor to the fixed single-response MEM stage.
- Supports a memory interface with variable latency (data_ok handshake) and up to MAX_OUTSTANDING in-flight loads/stores.
- Buffers early responses in a response FIFO and formats load data for DATA_W of 32 or 64 bits.
- On flush, discards responses belonging to cancelled requests.

---
 rtl/mem_load_stage_pkg.sv | 41 ++++
 rtl/mem_load_stage_if.sv | 54 +++++
 rtl/mem_load_stage_resp_fifo.sv | 86 ++++++++
 rtl/mem_load_stage.sv | 197 +++++++++++++++++++
 tb/tb_mem_load_stage.sv | 366 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_load_stage_pkg.sv
// -----------------------------------------------------------------------------
// mem_load_stage_pkg
// Shared definitions for the memory-access stage that sits between EX and WB.
// Provides:
//   - mem_size_e     : access size encodings (B/H/W/D)
//   - INFO_*_REL     : es_mem_info field positions relative to the offset field
//   - info_w()       : es_mem_info width for a given offset width
//   - ms_to_ws_w()   : width of {payload, ms_final_result} towards WB
//   - cnt_w()        : counter width able to hold 0..max_val
// -----------------------------------------------------------------------------
package mem_load_stage_pkg;

  typedef enum logic [1:0] {
    SIZE_B = 2'd0,
    SIZE_H = 2'd1,
    SIZE_W = 2'd2,
    SIZE_D = 2'd3   // only meaningful when DATA_W = 64
  } mem_size_e;

  // es_mem_info = {need_resp, ld_en, size[1:0], sign, ofs[OFS_W-1:0]}.
  // The offset occupies the low OFS_W bits; the fixed fields sit above it,
  // so their positions are expressed relative to OFS_W.
  localparam int INFO_SIGN_REL = 0;
  localparam int INFO_SIZE_REL = 1;  // two bits
  localparam int INFO_LD_REL   = 3;
  localparam int INFO_RESP_REL = 4;
  localparam int INFO_FIXED_W  = 5;

  function automatic int info_w(input int ofs_w);
    return ofs_w + INFO_FIXED_W;
  endfunction

  function automatic int ms_to_ws_w(input int pl_wd, input int data_w);
    return pl_wd + data_w;
  endfunction

  function automatic int cnt_w(input int max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/mem_load_stage_if.sv
// -----------------------------------------------------------------------------
// mem_load_stage_if
// Bundles every non-clock/reset signal of mem_load_stage.
//   slave  modport : the stage itself
//   master modport : the surroundings (EX, memory, WB, exception logic)
// Signals:
//   es_to_ms_valid / ms_allowin   EX -> MS instruction handshake
//   es_to_ms_bus, es_mem_info     latched payload and memory-access descriptor
//   es_req_issued / ms_req_block  request issue notification and back-pressure
//   data_sram_data_ok/_rdata      memory response
//   ms_to_ws_valid / ws_allowin   MS -> WB instruction handshake
//   ms_to_ws_bus                  {payload, ms_final_result}
//   flush                         exception/ertn flush
//
// Handshake rule (both instruction interfaces): a transfer happens in the
// cycle where valid and the receiver's allowin are both high; valid may not
// depend on the receiver's allowin, and the sender holds its data until then.
// -----------------------------------------------------------------------------
interface mem_load_stage_if
  import mem_load_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int PL_WD  = 136,
  parameter int OFS_W  = $clog2(DATA_W / 8)
);
  localparam int INFO_W = info_w(OFS_W);
  localparam int OUT_W  = ms_to_ws_w(PL_WD, DATA_W);

  logic              es_to_ms_valid;
  logic              ms_allowin;
  logic [PL_WD-1:0]  es_to_ms_bus;
  logic [INFO_W-1:0] es_mem_info;
  logic              es_req_issued;
  logic              ms_req_block;
  logic              data_sram_data_ok;
  logic [DATA_W-1:0] data_sram_rdata;
  logic              ws_allowin;
  logic              ms_to_ws_valid;
  logic [OUT_W-1:0]  ms_to_ws_bus;
  logic              flush;

  modport slave (
    input  es_to_ms_valid, es_to_ms_bus, es_mem_info, es_req_issued,
           data_sram_data_ok, data_sram_rdata, ws_allowin, flush,
    output ms_allowin, ms_req_block, ms_to_ws_valid, ms_to_ws_bus
  );

  modport master (
    output es_to_ms_valid, es_to_ms_bus, es_mem_info, es_req_issued,
           data_sram_data_ok, data_sram_rdata, ws_allowin, flush,
    input  ms_allowin, ms_req_block, ms_to_ws_valid, ms_to_ws_bus
  );

endinterface

// File: rtl/mem_load_stage_resp_fifo.sv
// -----------------------------------------------------------------------------
// mem_load_stage_resp_fifo
// Pointer-based response FIFO holding memory read data until the owning
// instruction leaves the stage.
// Ports:
//   clk, reset  clock, asynchronous active-high reset
//   push, push_data   write an entry
//   pop               drop the head entry
//   clr               discard all entries (wins over push/pop)
//   full, empty       occupancy flags
//   head              oldest entry (undefined while empty)
// Push and pop may coincide even when full: the pop frees the slot that the
// push then fills, so occupancy stays at DEPTH.
// -----------------------------------------------------------------------------
module mem_load_stage_resp_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             clr,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];

  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; validity is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (do_push && !clr) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/mem_load_stage.sv
// -----------------------------------------------------------------------------
// mem_load_stage
// Memory-access pipeline stage between EX and WB for a memory port with
// variable latency. Up to MAX_OUTSTANDING requests may be in flight; responses
// are buffered in a FIFO until their instruction leaves towards WB, and load
// data is aligned and sign/zero-extended to DATA_W (32 or 64).
// Ports:
//   clk    clock
//   reset  asynchronous active-high reset
//   ms_if  mem_load_stage_if.slave (EX handshake, memory response,
//          WB handshake, flush)
// Flush drops the instruction in the stage, empties the FIFO and arms a
// cancel counter so that responses to already-issued requests are discarded.
// -----------------------------------------------------------------------------
module mem_load_stage
  import mem_load_stage_pkg::*;
#(
  parameter int DATA_W          = 32,
  parameter int MAX_OUTSTANDING = 2,
  parameter int BUF_DEPTH       = 2,
  parameter int PL_WD           = 136,
  parameter int OFS_W           = $clog2(DATA_W / 8)
) (
  input logic           clk,
  input logic           reset,
  mem_load_stage_if.slave ms_if
);
  localparam int INFO_W = info_w(OFS_W);
  localparam int CNT_W  = cnt_w(MAX_OUTSTANDING);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic              ms_valid_q,    ms_valid_d;
  logic [PL_WD-1:0]  payload_q,     payload_d;
  logic [INFO_W-1:0] info_q,        info_d;
  logic [CNT_W-1:0]  outstanding_q, outstanding_d;
  logic [CNT_W-1:0]  cancel_q,      cancel_d;

  // Decoded fields of the latched access descriptor
  logic              need_resp_r;
  logic              ld_en_r;
  logic              sign_r;
  mem_size_e         size_r;
  logic [OFS_W-1:0]  ofs_r;

  assign ofs_r       = info_q[OFS_W-1:0];
  assign sign_r      = info_q[OFS_W + INFO_SIGN_REL];
  assign size_r      = mem_size_e'(info_q[OFS_W + INFO_SIZE_REL +: 2]);
  assign ld_en_r     = info_q[OFS_W + INFO_LD_REL];
  assign need_resp_r = info_q[OFS_W + INFO_RESP_REL];

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  logic fifo_push, fifo_pop, fifo_clr, fifo_full, fifo_empty;
  logic [DATA_W-1:0] fifo_head;
  logic ms_ready_go;
  logic ms_to_ws_fire;
  logic accept;
  logic resp_drop;

  assign ms_ready_go          = ~need_resp_r | ~fifo_empty;
  assign ms_if.ms_allowin     = ~ms_valid_q | (ms_ready_go & ms_if.ws_allowin);
  assign ms_if.ms_to_ws_valid = ms_valid_q & ms_ready_go & ~ms_if.flush;
  assign ms_to_ws_fire        = ms_if.ms_to_ws_valid & ms_if.ws_allowin;
  assign accept               = ms_if.es_to_ms_valid & ms_if.ms_allowin & ~ms_if.flush;
  assign ms_if.ms_req_block   = (outstanding_q == CNT_W'(MAX_OUTSTANDING));

  // A response belongs to a cancelled request while cancel_q is non-zero;
  // responses arriving during the flush cycle itself are also discarded.
  assign resp_drop = (cancel_q != '0);
  assign fifo_push = ms_if.data_sram_data_ok & ~resp_drop & ~ms_if.flush;
  assign fifo_pop  = ms_to_ws_fire & need_resp_r;
  assign fifo_clr  = ms_if.flush;

  always_comb begin
    ms_valid_d = ms_valid_q;
    payload_d  = payload_q;
    info_d     = info_q;
    if (ms_if.flush) begin
      ms_valid_d = 1'b0;
    end else if (ms_if.ms_allowin) begin
      ms_valid_d = ms_if.es_to_ms_valid;
    end
    if (accept) begin
      payload_d = ms_if.es_to_ms_bus;
      info_d    = ms_if.es_mem_info;
    end
  end

  // ---------------------------------------------------------------------------
  // Outstanding / cancel accounting
  // ---------------------------------------------------------------------------
  // outstanding_q counts every request not yet answered, including ones whose
  // answer will be dropped; a flush therefore re-arms cancel_q with the full
  // in-flight count, which also covers flushes that arrive while earlier
  // cancels are still pending.
  always_comb begin
    outstanding_d = outstanding_q;
    if (ms_if.es_req_issued && !ms_if.data_sram_data_ok) begin
      outstanding_d = outstanding_q + CNT_W'(1);
    end else if (!ms_if.es_req_issued && ms_if.data_sram_data_ok) begin
      outstanding_d = outstanding_q - CNT_W'(1);
    end

    cancel_d = cancel_q;
    if (ms_if.flush) begin
      cancel_d = outstanding_d;
    end else if (ms_if.data_sram_data_ok && resp_drop) begin
      cancel_d = cancel_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ms_valid_q    <= 1'b0;
      payload_q     <= '0;
      info_q        <= '0;
      outstanding_q <= '0;
      cancel_q      <= '0;
    end else begin
      ms_valid_q    <= ms_valid_d;
      payload_q     <= payload_d;
      info_q        <= info_d;
      outstanding_q <= outstanding_d;
      cancel_q      <= cancel_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Response FIFO
  // ---------------------------------------------------------------------------
  mem_load_stage_resp_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (BUF_DEPTH)
  ) u_resp_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (ms_if.data_sram_rdata),
    .pop       (fifo_pop),
    .clr       (fifo_clr),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head)
  );

  // Responses can never exceed the outstanding limit, so a push into a full
  // FIFO without a simultaneous pop means the memory side misbehaved.
  always @(posedge clk) begin
    if (!reset) assert (!(fifo_push && fifo_full && !fifo_pop));
  end

  // ---------------------------------------------------------------------------
  // Load alignment and extension
  // ---------------------------------------------------------------------------
  // Shifting by ofs*8 brings the addressed lane to bit 0; for a 64-bit bus a
  // word access with ofs[2]=1 thus selects the upper half.
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] keep_mask;
  logic              msb_bit;
  logic [DATA_W-1:0] ld_data;
  logic [DATA_W-1:0] ms_final_result;

  always_comb begin
    shifted = fifo_head >> {ofs_r, 3'b000};
    case (size_r)
      SIZE_B: begin
        keep_mask = DATA_W'(8'hFF);
        msb_bit   = shifted[7];
      end
      SIZE_H: begin
        keep_mask = DATA_W'(16'hFFFF);
        msb_bit   = shifted[15];
      end
      SIZE_W: begin
        keep_mask = DATA_W'(32'hFFFF_FFFF);
        msb_bit   = shifted[31];
      end
      SIZE_D: begin
        keep_mask = '1;
        msb_bit   = shifted[DATA_W-1];
      end
      default: begin
        keep_mask = '1;
        msb_bit   = shifted[DATA_W-1];
      end
    endcase
    ld_data = (shifted & keep_mask) | (~keep_mask & {DATA_W{sign_r & msb_bit}});
  end

  // Non-load instructions forward the ALU result held in the payload LSBs.
  assign ms_final_result    = ld_en_r ? ld_data : payload_q[DATA_W-1:0];
  assign ms_if.ms_to_ws_bus = {payload_q, ms_final_result};

endmodule

// File: tb/tb_mem_load_stage.sv
module tb_mem_load_stage;
  import mem_load_stage_pkg::*;

  localparam int PL_WD = 136;
  localparam int W32   = PL_WD + 32;
  localparam int W64   = PL_WD + 64;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_load_stage_if #(.DATA_W(32), .PL_WD(PL_WD)) if32 ();
  mem_load_stage_if #(.DATA_W(64), .PL_WD(PL_WD)) if64 ();

  mem_load_stage #(
    .DATA_W(32), .MAX_OUTSTANDING(2), .BUF_DEPTH(2), .PL_WD(PL_WD)
  ) dut32 (
    .clk   (clk),
    .reset (reset),
    .ms_if (if32.slave)
  );

  mem_load_stage #(
    .DATA_W(64), .MAX_OUTSTANDING(2), .BUF_DEPTH(2), .PL_WD(PL_WD)
  ) dut64 (
    .clk   (clk),
    .reset (reset),
    .ms_if (if64.slave)
  );

  // ---------------------------------------------------------------------------
  // Bookkeeping
  // ---------------------------------------------------------------------------
  int checks = 0;
  int errors = 0;

  logic [W32-1:0] exp32_q[$];
  logic [W64-1:0] exp64_q[$];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Scoreboards: every transfer to WB is compared with the oldest expectation.
  always @(negedge clk) begin
    if (reset === 1'b0 && if32.ms_to_ws_valid && if32.ws_allowin) begin
      if (exp32_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL wb32_unexpected actual=%0h required=none", if32.ms_to_ws_bus);
      end else begin
        check("wb32_result", if32.ms_to_ws_bus, exp32_q.pop_front());
      end
    end
    if (reset === 1'b0 && if64.ms_to_ws_valid && if64.ws_allowin) begin
      if (exp64_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL wb64_unexpected actual=%0h required=none", if64.ms_to_ws_bus);
      end else begin
        check("wb64_result", if64.ms_to_ws_bus, exp64_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Driver helpers
  // ---------------------------------------------------------------------------
  function automatic logic [PL_WD-1:0] mk_pl(input logic [7:0] tag);
    return {17{tag}};
  endfunction

  function automatic logic [6:0] info32(input logic nr, input logic ld, input logic [1:0] size,
                                        input logic sign, input logic [1:0] ofs);
    return {nr, ld, size, sign, ofs};
  endfunction

  function automatic logic [7:0] info64(input logic nr, input logic ld, input logic [1:0] size,
                                        input logic sign, input logic [2:0] ofs);
    return {nr, ld, size, sign, ofs};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    if32.es_to_ms_valid = 1'b0; if32.es_to_ms_bus = '0; if32.es_mem_info = '0;
    if32.es_req_issued = 1'b0; if32.data_sram_data_ok = 1'b0; if32.data_sram_rdata = '0;
    if32.ws_allowin = 1'b1; if32.flush = 1'b0;
    if64.es_to_ms_valid = 1'b0; if64.es_to_ms_bus = '0; if64.es_mem_info = '0;
    if64.es_req_issued = 1'b0; if64.data_sram_data_ok = 1'b0; if64.data_sram_rdata = '0;
    if64.ws_allowin = 1'b1; if64.flush = 1'b0;
  endtask

  task automatic es32(input logic v, input logic [PL_WD-1:0] pl, input logic [6:0] info);
    if32.es_to_ms_valid = v;
    if32.es_to_ms_bus   = pl;
    if32.es_mem_info    = info;
  endtask

  // ---------------------------------------------------------------------------
  // Vector table: zero-wait accesses (request and response in the entry cycle)
  // ---------------------------------------------------------------------------
  typedef struct {
    logic        is64;
    logic        ld;
    logic [1:0]  size;
    logic        sign;
    logic [2:0]  ofs;
    logic [63:0] rdata;
    logic [63:0] exp;
  } vec_t;

  localparam int NVEC = 15;
  vec_t vecs[NVEC];

  function automatic vec_t mkv(input logic is64, input logic ld, input logic [1:0] size,
                               input logic sign, input logic [2:0] ofs,
                               input logic [63:0] rdata, input logic [63:0] exp);
    vec_t v;
    v.is64 = is64; v.ld = ld; v.size = size; v.sign = sign;
    v.ofs = ofs; v.rdata = rdata; v.exp = exp;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input logic [7:0] tag);
    logic [PL_WD-1:0] pl;
    logic [63:0]      exp_res;
    pl      = mk_pl(tag);
    exp_res = v.ld ? v.exp : pl[63:0];
    set_idle();
    if (v.is64) begin
      if64.es_to_ms_valid    = 1'b1;
      if64.es_to_ms_bus      = pl;
      if64.es_mem_info       = info64(v.ld, v.ld, v.size, v.sign, v.ofs);
      if64.es_req_issued     = v.ld;
      if64.data_sram_data_ok = v.ld;
      if64.data_sram_rdata   = v.rdata;
      exp64_q.push_back({pl, exp_res});
      #1 check("vec64_allowin", if64.ms_allowin, 1'b1);
    end else begin
      es32(1'b1, pl, info32(v.ld, v.ld, v.size, v.sign, v.ofs[1:0]));
      if32.es_req_issued     = v.ld;
      if32.data_sram_data_ok = v.ld;
      if32.data_sram_rdata   = v.rdata[31:0];
      exp32_q.push_back({pl, exp_res[31:0]});
      #1 check("vec32_allowin", if32.ms_allowin, 1'b1);
    end
    tick();
    set_idle();
    #1;
    if (v.is64) check("vec64_ready", if64.ms_to_ws_valid, 1'b1);
    else        check("vec32_ready", if32.ms_to_ws_valid, 1'b1);
    tick();
    if (v.is64) check("vec64_drained", if64.ms_to_ws_valid, 1'b0);
    else        check("vec32_drained", if32.ms_to_ws_valid, 1'b0);
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic [PL_WD-1:0] pl_a, pl_b, pl_c;

    vecs[0]  = mkv(0, 1, SIZE_B, 1, 3, 64'h80FF_0000, 64'hFFFF_FF80);
    vecs[1]  = mkv(0, 1, SIZE_B, 0, 3, 64'h80FF_0000, 64'h0000_0080);
    vecs[2]  = mkv(0, 1, SIZE_H, 1, 2, 64'h1234_5678, 64'h0000_1234);
    vecs[3]  = mkv(0, 1, SIZE_H, 1, 0, 64'h0000_8001, 64'hFFFF_8001);
    vecs[4]  = mkv(0, 1, SIZE_H, 0, 2, 64'hABCD_0000, 64'h0000_ABCD);
    vecs[5]  = mkv(0, 1, SIZE_W, 1, 0, 64'hDEAD_BEEF, 64'hDEAD_BEEF);
    vecs[6]  = mkv(0, 1, SIZE_B, 1, 1, 64'h0000_7F00, 64'h0000_007F);
    vecs[7]  = mkv(0, 0, SIZE_W, 0, 0, 64'h0,         64'h0);
    vecs[8]  = mkv(1, 1, SIZE_W, 1, 4, 64'h8000_0001_0000_0000, 64'hFFFF_FFFF_8000_0001);
    vecs[9]  = mkv(1, 1, SIZE_W, 0, 4, 64'h8000_0001_0000_0000, 64'h0000_0000_8000_0001);
    vecs[10] = mkv(1, 1, SIZE_D, 0, 0, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF);
    vecs[11] = mkv(1, 1, SIZE_B, 1, 7, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FF80);
    vecs[12] = mkv(1, 1, SIZE_H, 0, 6, 64'h1234_0000_0000_0000, 64'h0000_0000_0000_1234);
    vecs[13] = mkv(1, 0, SIZE_W, 0, 0, 64'h0,         64'h0);
    vecs[14] = mkv(1, 1, SIZE_W, 1, 0, 64'h0000_0000_7FFF_FFFF, 64'h0000_0000_7FFF_FFFF);

    // Reset state
    reset = 1'b1;
    set_idle();
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid32",  if32.ms_to_ws_valid, 1'b0);
    check("rst_allowin32", if32.ms_allowin,    1'b1);
    check("rst_block32",  if32.ms_req_block,   1'b0);
    check("rst_valid64",  if64.ms_to_ws_valid, 1'b0);
    check("rst_allowin64", if64.ms_allowin,    1'b1);
    #2 reset = 1'b0;
    tick();

    for (int i = 0; i < NVEC; i++) run_vec(vecs[i], 8'hA0 + 8'(i));

    // Latency 3: three waiting cycles, then ld.h ofs=2
    set_idle();
    pl_a = mk_pl(8'h31);
    es32(1'b1, pl_a, info32(1, 1, SIZE_H, 1, 2'd2));
    if32.es_req_issued = 1'b1;
    exp32_q.push_back({pl_a, 32'h0000_1234});
    tick();
    set_idle();
    for (int c = 0; c < 3; c++) begin
      if (c == 2) begin
        if32.data_sram_data_ok = 1'b1;
        if32.data_sram_rdata   = 32'h1234_5678;
      end
      #1 check("lat3_wait", if32.ms_to_ws_valid, 1'b0);
      tick();
      set_idle();
    end
    #1 check("lat3_ready", if32.ms_to_ws_valid, 1'b1);
    tick();
    check("lat3_drained", if32.ms_to_ws_valid, 1'b0);

    // Two outstanding, responses buffered while WB stalls
    set_idle();
    pl_a = mk_pl(8'h41);
    pl_b = mk_pl(8'h42);
    es32(1'b1, pl_a, info32(1, 1, SIZE_W, 0, 2'd0));
    if32.es_req_issued = 1'b1;
    exp32_q.push_back({pl_a, 32'hA0A0_0001});
    tick();
    set_idle();
    es32(1'b1, pl_b, info32(1, 1, SIZE_B, 1, 2'd1));
    if32.es_req_issued = 1'b1;
    #1 check("two_hold_allowin", if32.ms_allowin, 1'b0);
    check("two_block_one", if32.ms_req_block, 1'b0);
    tick();
    if32.es_req_issued     = 1'b0;
    if32.ws_allowin        = 1'b0;
    if32.data_sram_data_ok = 1'b1;
    if32.data_sram_rdata   = 32'hA0A0_0001;
    #1 check("two_block_full", if32.ms_req_block, 1'b1);
    tick();
    if32.data_sram_rdata = 32'h0000_8000;
    #1 check("two_valid_stalled", if32.ms_to_ws_valid, 1'b1);
    check("two_allowin_stalled", if32.ms_allowin, 1'b0);
    check("two_block_released", if32.ms_req_block, 1'b0);
    tick();
    if32.data_sram_data_ok = 1'b0;
    #1 check("two_fifo_full_valid", if32.ms_to_ws_valid, 1'b1);
    tick();
    if32.ws_allowin = 1'b1;
    exp32_q.push_back({pl_b, 32'hFFFF_FF80});
    #1 check("two_drain_allowin", if32.ms_allowin, 1'b1);
    tick();
    set_idle();
    #1 check("two_second_ready", if32.ms_to_ws_valid, 1'b1);
    tick();
    check("two_drained", if32.ms_to_ws_valid, 1'b0);

    // Flush with two outstanding; one response lands in the flush cycle
    set_idle();
    pl_a = mk_pl(8'h51);
    pl_b = mk_pl(8'h52);
    pl_c = mk_pl(8'h53);
    es32(1'b1, pl_a, info32(1, 1, SIZE_W, 0, 2'd0));
    if32.es_req_issued = 1'b1;
    tick();
    es32(1'b1, pl_b, info32(1, 1, SIZE_W, 0, 2'd0));
    if32.es_req_issued = 1'b1;
    tick();
    if32.es_req_issued     = 1'b0;
    if32.flush             = 1'b1;
    if32.data_sram_data_ok = 1'b1;
    if32.data_sram_rdata   = 32'hBAD0_0001;
    #1 check("flush_valid_low", if32.ms_to_ws_valid, 1'b0);
    tick();
    set_idle();
    es32(1'b1, pl_c, info32(1, 1, SIZE_W, 0, 2'd0));
    if32.es_req_issued     = 1'b1;
    if32.data_sram_data_ok = 1'b1;
    if32.data_sram_rdata   = 32'hBAD0_0002;
    exp32_q.push_back({pl_c, 32'h0C0C_0C0C});
    #1 check("flush_allowin", if32.ms_allowin, 1'b1);
    check("flush_empty", if32.ms_to_ws_valid, 1'b0);
    tick();
    set_idle();
    if32.data_sram_data_ok = 1'b1;
    if32.data_sram_rdata   = 32'h0C0C_0C0C;
    #1 check("flush_dropped_resp", if32.ms_to_ws_valid, 1'b0);
    tick();
    set_idle();
    #1 check("flush_new_ready", if32.ms_to_ws_valid, 1'b1);
    tick();
    check("flush_new_drained", if32.ms_to_ws_valid, 1'b0);
    check("flush_block_clear", if32.ms_req_block, 1'b0);

    // Flush of a ready instruction stalled by WB, then flush ignoring entry
    set_idle();
    pl_a = mk_pl(8'h61);
    es32(1'b1, pl_a, info32(1, 1, SIZE_W, 0, 2'd0));
    if32.es_req_issued     = 1'b1;
    if32.data_sram_data_ok = 1'b1;
    if32.data_sram_rdata   = 32'h6666_6666;
    tick();
    set_idle();
    if32.ws_allowin = 1'b0;
    if32.flush      = 1'b1;
    #1 check("flush_kills_valid", if32.ms_to_ws_valid, 1'b0);
    tick();
    set_idle();
    if32.flush = 1'b1;
    es32(1'b1, mk_pl(8'h62), info32(0, 0, SIZE_W, 0, 2'd0));
    #1 check("flush_idle_allowin", if32.ms_allowin, 1'b1);
    tick();
    set_idle();
    #1 check("flush_ignores_entry", if32.ms_to_ws_valid, 1'b0);
    run_vec(vecs[0], 8'h63);

    // Asynchronous reset while waiting with a non-empty FIFO
    set_idle();
    pl_a = mk_pl(8'h71);
    es32(1'b1, pl_a, info32(1, 1, SIZE_W, 0, 2'd0));
    if32.es_req_issued     = 1'b1;
    if32.data_sram_data_ok = 1'b1;
    if32.data_sram_rdata   = 32'h7777_7777;
    tick();
    set_idle();
    if32.ws_allowin    = 1'b0;
    if32.es_req_issued = 1'b1;
    tick();
    if32.ws_allowin    = 1'b0;
    if32.es_req_issued = 1'b1;
    tick();
    set_idle();
    if32.ws_allowin = 1'b0;
    #1 check("prerst_valid", if32.ms_to_ws_valid, 1'b1);
    check("prerst_block", if32.ms_req_block, 1'b1);
    #1 reset = 1'b1;
    #1 check("asyncrst_valid", if32.ms_to_ws_valid, 1'b0);
    check("asyncrst_allowin", if32.ms_allowin, 1'b1);
    check("asyncrst_block", if32.ms_req_block, 1'b0);
    @(posedge clk);
    #3 reset = 1'b0;
    tick();
    check("postrst_allowin", if32.ms_allowin, 1'b1);
    run_vec(vecs[0], 8'h72);
    run_vec(vecs[1], 8'h73);

    repeat (3) tick();
    check("sb32_drained", 32'(exp32_q.size()), 32'd0);
    check("sb64_drained", 32'(exp64_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
